// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and defaults for the I/D cache line refill arbiter.
package cache_refill_arbiter_pkg;

  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_refill_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the side that did not own the last line wins.
module rr_arb2
  import cache_refill_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  owner_t     last,
  output logic [1:0] win_c
);

  // One-hot winner, bit 0 = I side, bit 1 = D side
  always_comb begin
    win_c = 2'b00;
    if (i_req && d_req) begin
      win_c = (last == OWN_I) ? 2'b10 : 2'b01;
    end else if (i_req) begin
      win_c = 2'b01;
    end else if (d_req) begin
      win_c = 2'b10;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbitrates I/D cache misses and refills one line word-by-word from backing memory.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  input  logic                          d_req,
  input  logic [31:0]                   d_addr,
  output logic                          i_gnt,
  output logic                          d_gnt,
  output logic                          mem_rd,
  output logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_rvalid,
  output logic [31:0]                   fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic                          fill_valid_i,
  output logic                          fill_valid_d,
  output logic                          done_i,
  output logic                          done_d,
  output logic                          busy
);

  localparam int unsigned IDXW     = $clog2(LINE_WORDS);
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [31:0] OFF_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINE_WORDS - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  state_t          state, state_n;
  owner_t          owner, owner_n;
  owner_t          last, last_n;
  logic [31:0]     base, base_n;
  logic [IDXW-1:0] cnt, cnt_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic [1:0]      win_c;
  logic [31:0]     addr_sel;

  logic            i_gnt_n, d_gnt_n, mem_rd_n, busy_n;
  logic [31:0]     mem_addr_n, fill_data_n;
  logic [IDXW-1:0] fill_idx_n;
  logic            fill_valid_i_n, fill_valid_d_n, done_i_n, done_d_n;

  rr_arb2 u_rr_arb2 (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last),
    .win_c (win_c)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_I;
      last         <= OWN_D;
      base         <= '0;
      cnt          <= '0;
      tmo          <= '0;
      i_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      fill_data    <= '0;
      fill_idx     <= '0;
      fill_valid_i <= 1'b0;
      fill_valid_d <= 1'b0;
      done_i       <= 1'b0;
      done_d       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      last         <= last_n;
      base         <= base_n;
      cnt          <= cnt_n;
      tmo          <= tmo_n;
      i_gnt        <= i_gnt_n;
      d_gnt        <= d_gnt_n;
      mem_rd       <= mem_rd_n;
      mem_addr     <= mem_addr_n;
      fill_data    <= fill_data_n;
      fill_idx     <= fill_idx_n;
      fill_valid_i <= fill_valid_i_n;
      fill_valid_d <= fill_valid_d_n;
      done_i       <= done_i_n;
      done_d       <= done_d_n;
      busy         <= busy_n;
    end
  end

  // Next state and next output values; mem_rd/mem_addr/busy are derived from the next state
  always_comb begin
    state_n        = state;
    owner_n        = owner;
    last_n         = last;
    base_n         = base;
    cnt_n          = cnt;
    tmo_n          = tmo;
    i_gnt_n        = 1'b0;
    d_gnt_n        = 1'b0;
    fill_data_n    = fill_data;
    fill_idx_n     = fill_idx;
    fill_valid_i_n = 1'b0;
    fill_valid_d_n = 1'b0;
    done_i_n       = 1'b0;
    done_d_n       = 1'b0;
    addr_sel       = win_c[1] ? d_addr : i_addr;

    case (state)
      IDLE: begin
        if (|win_c) begin
          owner_n = win_c[1] ? OWN_D : OWN_I;
          base_n  = addr_sel & ~OFF_MASK;
          cnt_n   = '0;
          tmo_n   = '0;
          i_gnt_n = win_c[0];
          d_gnt_n = win_c[1];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tmo_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          fill_data_n    = mem_rdata;
          fill_idx_n     = cnt;
          fill_valid_i_n = (owner == OWN_I);
          fill_valid_d_n = (owner == OWN_D);
          cnt_n          = cnt + 1'b1;
          tmo_n          = '0;
          if (cnt == LAST_IDX) begin
            done_i_n = (owner == OWN_I);
            done_d_n = (owner == OWN_D);
            last_n   = owner;
            state_n  = IDLE;
          end else begin
            state_n = ISSUE;
          end
        end else if (tmo == TMO_LAST) begin
          tmo_n   = '0;
          state_n = ISSUE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    mem_rd_n   = (state_n == ISSUE);
    mem_addr_n = (state_n == ISSUE) ? (base_n + 32'({cnt_n, 2'b00})) : mem_addr;
    busy_n     = (state_n != IDLE);
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed, table-driven bench for cache_refill_arbiter with a 1-cycle-latency memory model.
module tb_cache_refill_arbiter;

  localparam int unsigned LW   = 4;
  localparam int unsigned TO   = 15;
  localparam int unsigned IDXW = $clog2(LW);

  logic            clk;
  logic            rst;
  logic            i_req, d_req;
  logic [31:0]     i_addr, d_addr;
  logic            i_gnt, d_gnt;
  logic            mem_rd;
  logic [31:0]     mem_addr, mem_rdata;
  logic            mem_rvalid;
  logic [31:0]     fill_data;
  logic [IDXW-1:0] fill_idx;
  logic            fill_valid_i, fill_valid_d, done_i, done_d, busy;

  int nchecks = 0;
  int nerr    = 0;

  // memory responder state
  logic        pend;
  logic [31:0] pend_addr;
  logic        drop_armed;
  logic [31:0] drop_addr;

  typedef struct {
    logic        side;    // 0 = I, 1 = D
    logic [31:0] addr;
    logic [31:0] base;    // hand-computed line base
    int          drop_w;  // word whose first read gets no reply, -1 for none
  } vec_t;

  vec_t vecs[6];

  cache_refill_arbiter #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .i_gnt        (i_gnt),
    .d_gnt        (d_gnt),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .fill_data    (fill_data),
    .fill_idx     (fill_idx),
    .fill_valid_i (fill_valid_i),
    .fill_valid_d (fill_valid_d),
    .done_i       (done_i),
    .done_d       (done_d),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({i_gnt, d_gnt, mem_rd, fill_valid_i, fill_valid_d,
                             done_i, done_d, busy, fill_idx}), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_fill_data"}, 64'(fill_data), 64'(0));
  endtask

  // Advance to the next falling edge, then act as memory: reply one cycle after each mem_rd
  task automatic cycle();
    @(negedge clk);
    mem_rvalid = 1'b0;
    if (pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_of(pend_addr);
      pend       = 1'b0;
    end
    if (mem_rd) begin
      if (drop_armed && mem_addr == drop_addr) begin
        drop_armed = 1'b0;
      end else begin
        pend      = 1'b1;
        pend_addr = mem_addr;
      end
    end
    chk("onehot", 64'((i_gnt & d_gnt) | (fill_valid_i & fill_valid_d) | (done_i & done_d)), 64'(0));
  endtask

  // Request must already be driven; runs from acceptance to the done cycle
  task automatic run_line(input logic side, input logic [31:0] base, input bit drop_req,
                          input int drop_w);
    logic [31:0] a;
    if (drop_w >= 0) begin
      drop_addr  = base + 32'(drop_w * 4);
      drop_armed = 1'b1;
    end
    cycle();
    chk("gnt_i", 64'(i_gnt), 64'(!side));
    chk("gnt_d", 64'(d_gnt), 64'(side));
    if (drop_req) begin
      if (side) d_req = 1'b0;
      else      i_req = 1'b0;
    end
    for (int w = 0; w < int'(LW); w++) begin
      a = base + 32'(w * 4);
      chk("issue_rd", 64'(mem_rd), 64'(1));
      chk("issue_addr", 64'(mem_addr), 64'(a));
      chk("issue_busy", 64'(busy), 64'(1));
      if (w == drop_w) begin
        for (int k = 0; k < int'(TO); k++) begin
          cycle();
          chk("to_wait_rd", 64'(mem_rd), 64'(0));
          chk("to_wait_fill", 64'({fill_valid_i, fill_valid_d}), 64'(0));
        end
        cycle();
        chk("reissue_rd", 64'(mem_rd), 64'(1));
        chk("reissue_addr", 64'(mem_addr), 64'(a));
      end
      cycle();
      chk("wait_rd", 64'(mem_rd), 64'(0));
      chk("wait_busy", 64'(busy), 64'(1));
      chk("gnt_pulse", 64'({i_gnt, d_gnt}), 64'(0));
      cycle();
      chk("fill_vi", 64'(fill_valid_i), 64'(!side));
      chk("fill_vd", 64'(fill_valid_d), 64'(side));
      chk("fill_idx", 64'(fill_idx), 64'(w));
      chk("fill_data", 64'(fill_data), 64'(word_of(a)));
      chk("done_i", 64'(done_i), 64'(!side && w == int'(LW) - 1));
      chk("done_d", 64'(done_d), 64'(side && w == int'(LW) - 1));
    end
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    vecs[0] = '{side: 1'b0, addr: 32'h0000_1234, base: 32'h0000_1230, drop_w: -1};
    vecs[1] = '{side: 1'b1, addr: 32'h8000_000F, base: 32'h8000_0000, drop_w: -1};
    vecs[2] = '{side: 1'b0, addr: 32'hFFFF_FFFC, base: 32'hFFFF_FFF0, drop_w: -1};
    vecs[3] = '{side: 1'b1, addr: 32'h0000_0000, base: 32'h0000_0000, drop_w: -1};
    vecs[4] = '{side: 1'b0, addr: 32'h0000_4008, base: 32'h0000_4000, drop_w: 2};
    vecs[5] = '{side: 1'b1, addr: 32'h1234_5678, base: 32'h1234_5670, drop_w: -1};

    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    pend = 1'b0; pend_addr = '0; drop_armed = 1'b0; drop_addr = '0;

    // asynchronous reset, checked before any clock edge
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // stray mem_rvalid in IDLE
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    cycle();
    chk("stray_fill", 64'({fill_valid_i, fill_valid_d}), 64'(0));
    chk("stray_busy", 64'({busy, mem_rd}), 64'(0));
    chk("stray_data", 64'(fill_data), 64'(0));

    // single-requester lines, including a dropped reply on word 2
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].side) begin d_req = 1'b1; d_addr = vecs[v].addr; end
      else              begin i_req = 1'b1; i_addr = vecs[v].addr; end
      run_line(vecs[v].side, vecs[v].base, 1'b1, vecs[v].drop_w);
    end

    // reset during WAIT of word 1
    d_req = 1'b1; d_addr = 32'h2000_0044;
    cycle();
    chk("mid_gnt_d", 64'(d_gnt), 64'(1));
    d_req = 1'b0;
    cycle(); cycle(); cycle();
    chk("mid_in_wait", 64'({busy, mem_rd}), 64'(2'b10));
    #2 rst = 1'b1;
    pend = 1'b0;
    #1 chk_all_zero("mid_reset");
    cycle();
    chk_all_zero("mid_reset_hold");
    cycle();
    chk("mid_no_done", 64'({done_i, done_d}), 64'(0));
    rst = 1'b0;
    d_req = 1'b1;
    run_line(1'b1, 32'h2000_0040, 1'b1, -1);

    // contention from reset: I, D, I with both requests held
    rst = 1'b1;
    pend = 1'b0;
    cycle();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_addr = 32'h0000_2008;
    run_line(1'b0, 32'h0000_1000, 1'b0, -1);
    run_line(1'b1, 32'h0000_2000, 1'b0, -1);
    run_line(1'b0, 32'h0000_1000, 1'b0, -1);
    i_req = 1'b0; d_req = 1'b0;
    cycle();
    chk("final_idle", 64'({busy, i_gnt, d_gnt}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
